// File: rtl/approx_mul_err_monitor.sv
// Error-statistics monitor for an approximate multiplier: recomputes the exact product
// and accumulates error count, ED sum, max ED and its operands over a programmed run.
module approx_mul_err_monitor #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   approx_prod,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [WIDTH-1:0]     max_a,
    output logic [WIDTH-1:0]     max_b
);

    localparam int PW    = 2 * WIDTH;
    localparam int EXT_W = ((ACC_W > PW) ? ACC_W : PW) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
        if (x >= y) begin
            return x - y;
        end else begin
            return y - x;
        end
    endfunction

    // Sum is formed wide enough for either operand so a large ED cannot wrap before the check
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [PW-1:0] ed);
        logic [EXT_W-1:0] s;
        s = EXT_W'(acc) + EXT_W'(ed);
        if (|s[EXT_W-1:ACC_W]) begin
            return '1;
        end else begin
            return s[ACC_W-1:0];
        end
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0]   sum_ed_q, sum_ed_d;
    logic [PW-1:0]      max_ed_q, max_ed_d;
    logic [WIDTH-1:0]   max_a_q, max_a_d;
    logic [WIDTH-1:0]   max_b_q, max_b_d;

    logic               v1_q, v2_q;
    logic [WIDTH-1:0]   a1_q, b1_q, a2_q, b2_q;
    logic [PW-1:0]      p1_q, ed2_q;

    logic               in_ready_s, accept_s, start_go_s, zero_s, run_end_s;
    logic [PW-1:0]      exact_s;

    assign in_ready_s = (state_q == ST_RUN) && (sample_cnt_q < target_q);
    assign accept_s   = in_valid && in_ready_s;
    assign start_go_s = start && !clear && (state_q != ST_RUN);
    assign zero_s     = clear || start_go_s;
    assign run_end_s  = (sample_cnt_q == target_q) && !v1_q && !v2_q;
    assign exact_s    = PW'(a1_q) * PW'(b1_q);

    // Next-state logic: clear dominates start, start only honoured outside RUN
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (clear) begin
            state_d  = ST_IDLE;
            target_d = '0;
        end else if (start_go_s) begin
            state_d  = ST_RUN;
            target_d = num_samples;
        end else begin
            case (state_q)
                ST_RUN:           state_d = run_end_s ? ST_DONE : ST_RUN;
                ST_IDLE, ST_DONE: state_d = state_q;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Statistics update from the S3 stage, sample counter from the accept handshake
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_ed_d     = sum_ed_q;
        max_ed_d     = max_ed_q;
        max_a_d      = max_a_q;
        max_b_d      = max_b_q;
        if (zero_s) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_ed_d     = '0;
            max_ed_d     = '0;
            max_a_d      = '0;
            max_b_d      = '0;
        end else begin
            if (accept_s) begin
                sample_cnt_d = sample_cnt_q + CNT_W'(1);
            end else begin
                sample_cnt_d = sample_cnt_q;
            end
            if (v2_q) begin
                err_cnt_d = (ed2_q != '0) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
                sum_ed_d  = sat_add(sum_ed_q, ed2_q);
                if (ed2_q > max_ed_q) begin
                    max_ed_d = ed2_q;
                    max_a_d  = a2_q;
                    max_b_d  = b2_q;
                end else begin
                    max_ed_d = max_ed_q;
                end
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end
    end

    // Control and statistics registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_ed_q     <= '0;
            max_ed_q     <= '0;
            max_a_q      <= '0;
            max_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_ed_q     <= sum_ed_d;
            max_ed_q     <= max_ed_d;
            max_a_q      <= max_a_d;
            max_b_q      <= max_b_d;
        end
    end

    // S1/S2 pipeline; clear kills both valids so dropped samples never reach S3
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            p1_q  <= '0;
            a2_q  <= '0;
            b2_q  <= '0;
            ed2_q <= '0;
        end else begin
            v1_q <= accept_s && !clear;
            v2_q <= v1_q && !clear;
            if (accept_s) begin
                a1_q <= a;
                b1_q <= b;
                p1_q <= approx_prod;
            end else begin
                a1_q <= a1_q;
                b1_q <= b1_q;
                p1_q <= p1_q;
            end
            if (v1_q) begin
                a2_q  <= a1_q;
                b2_q  <= b1_q;
                ed2_q <= abs_diff(exact_s, p1_q);
            end else begin
                a2_q  <= a2_q;
                b2_q  <= b2_q;
                ed2_q <= ed2_q;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_ed     = sum_ed_q;
    assign max_ed     = max_ed_q;
    assign max_a      = max_a_q;
    assign max_b      = max_b_q;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Directed self-checking bench for approx_mul_err_monitor (default and ACC_W=4 instances).
module tb_approx_mul_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] num_samples = 16'd0;
    logic        in_valid = 1'b0;
    logic [5:0]  a = 6'd0;
    logic [5:0]  b = 6'd0;
    logic [11:0] approx_prod = 12'd0;

    logic        in_ready, busy, done;
    logic [15:0] sample_cnt, err_cnt;
    logic [31:0] sum_ed;
    logic [11:0] max_ed;
    logic [5:0]  max_a, max_b;

    logic        in_ready4, busy4, done4;
    logic [15:0] sample_cnt4, err_cnt4;
    logic [3:0]  sum_ed4;
    logic [11:0] max_ed4;
    logic [5:0]  max_a4, max_b4;

    int n_checks = 0;
    int n_fail = 0;

    logic [5:0]  va [16];
    logic [5:0]  vb [16];
    logic [11:0] vp [16];

    always #5 clk = ~clk;

    approx_mul_err_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx_prod(approx_prod),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed),
        .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
    );

    approx_mul_err_monitor #(.WIDTH(6), .CNT_W(16), .ACC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .clear(clear), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b), .approx_prod(approx_prod),
        .busy(busy4), .done(done4), .sample_cnt(sample_cnt4), .err_cnt(err_cnt4), .sum_ed(sum_ed4),
        .max_ed(max_ed4), .max_a(max_a4), .max_b(max_b4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [5:0] x, input logic [5:0] y, input logic [11:0] p);
        va[i] = x;
        vb[i] = y;
        vp[i] = p;
    endtask

    task automatic send_all(input int n, input bit use4);
        for (int i = 0; i < n; i++) begin
            a = va[i];
            b = vb[i];
            approx_prod = vp[i];
            in_valid = 1'b1;
            n_checks++;
            if ((use4 ? in_ready4 : in_ready) !== 1'b1) begin
                n_fail++;
                $display("FAIL send_ready[%0d]: got %b want 1", i, use4 ? in_ready4 : in_ready);
            end
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        n_checks++;
        if ({busy, done, in_ready, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b} !== 91'd0) begin
            n_fail++;
            $display("FAIL reset_main: got %h want 0",
                     {busy, done, in_ready, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b});
        end
        tick;
        n_checks++;
        if ({busy4, done4, in_ready4, sample_cnt4, sum_ed4} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_acc4: got %h want 0", {busy4, done4, in_ready4, sample_cnt4, sum_ed4});
        end
    endtask

    task automatic test_exact;
        num_samples = 16'd4;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++;
        if ({busy, done, in_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL exact_start: got %b want 101", {busy, done, in_ready});
        end
        set_vec(0, 6'd3, 6'd5, 12'd15);
        set_vec(1, 6'd63, 6'd63, 12'd3969);
        set_vec(2, 6'd0, 6'd7, 12'd0);
        set_vec(3, 6'd12, 6'd10, 12'd120);
        send_all(4, 1'b0);
        tick;
        tick;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL exact_done_early: got %b want 0", done);
        end
        n_checks++;
        if ({sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b} !== {16'd4, 16'd0, 32'd0, 12'd0, 6'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL exact_stats: got %h want %h", {sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b},
                     {16'd4, 16'd0, 32'd0, 12'd0, 6'd0, 6'd0});
        end
        tick;
        n_checks++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL exact_done: got busy,done=%b want 01", {busy, done});
        end
    endtask

    task automatic test_errors;
        num_samples = 16'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        set_vec(0, 6'd63, 6'd63, 12'd3968);
        set_vec(1, 6'd5, 6'd7, 12'd35);
        set_vec(2, 6'd10, 6'd10, 12'd96);
        send_all(3, 1'b0);
        tick;
        tick;
        tick;
        n_checks++;
        if ({done, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b} !==
            {1'b1, 16'd3, 16'd2, 32'd5, 12'd4, 6'd10, 6'd10}) begin
            n_fail++;
            $display("FAIL errors_stats: got %h want %h", {done, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b},
                     {1'b1, 16'd3, 16'd2, 32'd5, 12'd4, 6'd10, 6'd10});
        end
    endtask

    task automatic test_tie;
        num_samples = 16'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        set_vec(0, 6'd2, 6'd2, 12'd3);
        set_vec(1, 6'd3, 6'd3, 12'd8);
        send_all(2, 1'b0);
        tick;
        tick;
        tick;
        n_checks++;
        if ({done, err_cnt, sum_ed, max_ed, max_a, max_b} !== {1'b1, 16'd2, 32'd2, 12'd1, 6'd2, 6'd2}) begin
            n_fail++;
            $display("FAIL tie_stats: got %h want %h", {done, err_cnt, sum_ed, max_ed, max_a, max_b},
                     {1'b1, 16'd2, 32'd2, 12'd1, 6'd2, 6'd2});
        end
    endtask

    task automatic test_saturate;
        num_samples = 16'd3;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        for (int i = 0; i < 3; i++) set_vec(i, 6'd3, 6'd3, 12'd15);
        send_all(3, 1'b1);
        n_checks++;
        if (sum_ed4 !== 4'd6) begin
            n_fail++;
            $display("FAIL sat_sum1: got %0d want 6", sum_ed4);
        end
        tick;
        n_checks++;
        if (sum_ed4 !== 4'd12) begin
            n_fail++;
            $display("FAIL sat_sum2: got %0d want 12", sum_ed4);
        end
        tick;
        n_checks++;
        if ({done4, sum_ed4} !== {1'b0, 4'd15}) begin
            n_fail++;
            $display("FAIL sat_sum3: got done,sum=%b,%0d want 0,15", done4, sum_ed4);
        end
        tick;
        n_checks++;
        if ({done4, sum_ed4, err_cnt4, max_ed4} !== {1'b1, 4'd15, 16'd3, 12'd6}) begin
            n_fail++;
            $display("FAIL sat_final: got %h want %h", {done4, sum_ed4, err_cnt4, max_ed4},
                     {1'b1, 4'd15, 16'd3, 12'd6});
        end
        n_checks++;
        if ({busy, done, in_ready, sample_cnt} !== {3'b010, 16'd2}) begin
            n_fail++;
            $display("FAIL sat_main_idle: got %h want %h", {busy, done, in_ready, sample_cnt}, {3'b010, 16'd2});
        end
    endtask

    task automatic test_zero_len;
        num_samples = 16'd0;
        in_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++;
        if ({busy, done, in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_run: got %b want 100", {busy, done, in_ready});
        end
        tick;
        in_valid = 1'b0;
        n_checks++;
        if ({busy, done, in_ready, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b} !== {3'b010, 88'd0}) begin
            n_fail++;
            $display("FAIL zero_done: got %h want %h",
                     {busy, done, in_ready, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b}, {3'b010, 88'd0});
        end
    endtask

    task automatic test_clear_back_to_back;
        num_samples = 16'd8;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 3; i++) set_vec(i, 6'd1, 6'd1, 12'd0);
        send_all(3, 1'b0);
        n_checks++;
        if ({sample_cnt, err_cnt} !== {16'd3, 16'd1}) begin
            n_fail++;
            $display("FAIL clr_midrun: got cnt,err=%0d,%0d want 3,1", sample_cnt, err_cnt);
        end
        a = 6'd9;
        b = 6'd9;
        approx_prod = 12'd0;
        in_valid = 1'b1;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        n_checks++;
        if ({busy, done, in_ready, sample_cnt, err_cnt, sum_ed, max_ed} !== 79'd0) begin
            n_fail++;
            $display("FAIL clr_idle: got %h want 0", {busy, done, in_ready, sample_cnt, err_cnt, sum_ed, max_ed});
        end
        tick;
        tick;
        tick;
        n_checks++;
        if ({busy, in_ready, sample_cnt, err_cnt, sum_ed, max_ed} !== 78'd0) begin
            n_fail++;
            $display("FAIL clr_hold: got %h want 0", {busy, in_ready, sample_cnt, err_cnt, sum_ed, max_ed});
        end
        in_valid = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        set_vec(0, 6'd1, 6'd1, 12'd0);
        set_vec(1, 6'd2, 6'd3, 12'd6);
        set_vec(2, 6'd7, 6'd9, 12'd60);
        set_vec(3, 6'd8, 6'd8, 12'd64);
        set_vec(4, 6'd15, 6'd15, 12'd230);
        set_vec(5, 6'd20, 6'd3, 12'd55);
        set_vec(6, 6'd0, 6'd0, 12'd0);
        set_vec(7, 6'd63, 6'd1, 12'd62);
        send_all(8, 1'b0);
        n_checks++;
        if ({busy, in_ready, sample_cnt} !== {2'b10, 16'd8}) begin
            n_fail++;
            $display("FAIL b2b_cap: got busy,ready,cnt=%b,%b,%0d want 1,0,8", busy, in_ready, sample_cnt);
        end
        tick;
        tick;
        n_checks++;
        if ({done, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b} !==
            {1'b0, 16'd8, 16'd5, 32'd15, 12'd5, 6'd15, 6'd15}) begin
            n_fail++;
            $display("FAIL b2b_stats: got %h want %h", {done, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b},
                     {1'b0, 16'd8, 16'd5, 32'd15, 12'd5, 6'd15, 6'd15});
        end
        tick;
        n_checks++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_done: got busy,done=%b want 01", {busy, done});
        end
    endtask

    initial begin
        test_reset;
        test_exact;
        test_errors;
        test_tie;
        test_saturate;
        test_zero_len;
        test_clear_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
